// File: rtl/vga_timing_gen.sv
// ============================================================================
// vga_timing_gen : 1024x768@60 display timing generator (h/v scan, syncs, pulses)
// Revision 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 1024,
  parameter int unsigned H_FPORCH  = 24,
  parameter int unsigned H_SYNC    = 136,
  parameter int unsigned H_BPORCH  = 160,
  parameter int unsigned V_VISIBLE = 768,
  parameter int unsigned V_FPORCH  = 3,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BPORCH  = 29,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        pix_ce,
  output logic [11:0] pixel_column,
  output logic [11:0] pixel_row,
  output logic        video_on,
  output logic        horiz_sync,
  output logic        vert_sync,
  output logic        frame_start,
  output logic        line_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FPORCH + H_SYNC + H_BPORCH;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FPORCH + V_SYNC + V_BPORCH;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS      = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS      = 12'(V_VISIBLE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_VISIBLE + H_FPORCH);
  localparam logic [11:0] H_SYNC_END = 12'(H_VISIBLE + H_FPORCH + H_SYNC);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_VISIBLE + V_FPORCH);
  localparam logic [11:0] V_SYNC_END = 12'(V_VISIBLE + V_FPORCH + V_SYNC);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic [11:0] col_q, col_d;
  logic [11:0] row_q, row_d;
  logic        von_q, von_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        fs_q, fs_d;
  logic        ls_q, ls_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    von_d   = von_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    fs_d    = 1'b0;
    ls_d    = 1'b0;

    if (pix_ce) begin
      // Output stage samples the decode of the counters before they advance,
      // so every output describes the same pixel.
      col_d = h_cnt_q;
      row_d = v_cnt_q;
      von_d = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      hs_d  = ((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      vs_d  = ((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      ls_d  = (h_cnt_q == 12'd0);
      fs_d  = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);

      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 12'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
      end else begin
        h_cnt_d = h_cnt_q + 12'd1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      h_cnt_q <= 12'd0;
      v_cnt_q <= 12'd0;
      col_q   <= 12'd0;
      row_q   <= 12'd0;
      von_q   <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      von_q   <= von_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
    end
  end

  assign pixel_column = col_q;
  assign pixel_row    = row_q;
  assign video_on     = von_q;
  assign horiz_sync   = hs_q;
  assign vert_sync    = vs_q;
  assign frame_start  = fs_q;
  assign line_start   = ls_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// tb_vga_timing_gen : scoreboard bench for vga_timing_gen (full-size and small-timing instances)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  typedef struct packed {
    logic [11:0] col;
    logic [11:0] row;
    logic        von;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        ls;
  } out_t;

  typedef struct {
    logic ce;
    out_t exp;
  } vec_t;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic pix_ce;

  logic [11:0] b_col, b_row, s_col, s_row;
  logic b_von, b_hs, b_vs, b_fs, b_ls;
  logic s_von, s_hs, s_vs, s_fs, s_ls;

  int vectors = 0;
  int miscompares = 0;

  out_t qb[$];
  out_t qs[$];
  out_t blast, slast, cur_b, cur_s;
  int bh, bv, sh, sv;

  always #5 HCLK = ~HCLK;

  vga_timing_gen dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .pix_ce(pix_ce),
    .pixel_column(b_col), .pixel_row(b_row), .video_on(b_von),
    .horiz_sync(b_hs), .vert_sync(b_vs), .frame_start(b_fs), .line_start(b_ls)
  );

  // Small timing (15 x 10 total) with active-high syncs so whole frames fit in a short run.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FPORCH(2), .H_SYNC(3), .H_BPORCH(2),
    .V_VISIBLE(6), .V_FPORCH(1), .V_SYNC(2), .V_BPORCH(1),
    .SYNC_POL(1'b1)
  ) dut_s (
    .HCLK(HCLK), .HRESETn(HRESETn), .pix_ce(pix_ce),
    .pixel_column(s_col), .pixel_row(s_row), .video_on(s_von),
    .horiz_sync(s_hs), .vert_sync(s_vs), .frame_start(s_fs), .line_start(s_ls)
  );

  function automatic out_t model_out(int h, int v, int hv, int hf, int hsw,
                                     int vv, int vf, int vsw, bit pol);
    out_t o;
    o.col = 12'(h);
    o.row = 12'(v);
    o.von = (h < hv) && (v < vv);
    o.hs  = ((h >= hv + hf) && (h < hv + hf + hsw)) ? pol : !pol;
    o.vs  = ((v >= vv + vf) && (v < vv + vf + vsw)) ? pol : !pol;
    o.fs  = (h == 0) && (v == 0);
    o.ls  = (h == 0);
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    bh = 0; bv = 0; sh = 0; sv = 0;
    blast = '{col: 12'd0, row: 12'd0, von: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, ls: 1'b0};
    slast = '{col: 12'd0, row: 12'd0, von: 1'b0, hs: 1'b0, vs: 1'b0, fs: 1'b0, ls: 1'b0};
    qb.delete();
    qs.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_b_rst"}, 32'({b_col, b_row, b_von, b_hs, b_vs, b_fs, b_ls}),
        32'({12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
    chk({tag, "_s_rst"}, 32'({s_col, s_row, s_von, s_hs, s_vs, s_fs, s_ls}),
        32'({12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
  endtask

  // Drive one HCLK cycle, push the expectation, then pop and compare after the edge.
  task automatic drive(input logic ce, input bit use_tab, input out_t tabexp);
    out_t eb, es;
    if (ce) begin
      eb = model_out(bh, bv, 1024, 24, 136, 768, 3, 6, 1'b0);
      es = model_out(sh, sv, 8, 2, 3, 6, 1, 2, 1'b1);
      if (bh == 1343) begin bh = 0; bv = (bv == 805) ? 0 : bv + 1; end else bh++;
      if (sh == 14)   begin sh = 0; sv = (sv == 9)   ? 0 : sv + 1; end else sh++;
    end else begin
      eb = blast; eb.fs = 1'b0; eb.ls = 1'b0;
      es = slast; es.fs = 1'b0; es.ls = 1'b0;
    end
    blast = eb;
    slast = es;
    qb.push_back(use_tab ? tabexp : eb);
    qs.push_back(es);
    pix_ce = ce;
    @(posedge HCLK);
    #1;
    cur_b = qb.pop_front();
    cur_s = qs.pop_front();
    chk("big_out", 32'({b_col, b_row, b_von, b_hs, b_vs, b_fs, b_ls}), 32'(cur_b));
    chk("small_out", 32'({s_col, s_row, s_von, s_hs, s_vs, s_fs, s_ls}), 32'(cur_s));
  endtask

  vec_t tab[7];

  initial begin
    int hs_low;
    int cyc;
    int prev_fs;
    int vs_cnt;

    tab[0] = '{ce: 1'b1, exp: '{12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}};
    tab[1] = '{ce: 1'b0, exp: '{12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tab[2] = '{ce: 1'b0, exp: '{12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tab[3] = '{ce: 1'b1, exp: '{12'd1, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tab[4] = '{ce: 1'b1, exp: '{12'd2, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tab[5] = '{ce: 1'b0, exp: '{12'd2, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tab[6] = '{ce: 1'b1, exp: '{12'd3, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};

    HRESETn = 1'b0;
    pix_ce  = 1'b0;
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    chk_reset("init");
    HRESETn = 1'b1;

    // Idle cycles after release keep the reset values.
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 7; i++) drive(tab[i].ce, 1'b1, tab[i].exp);

    // Continuous run through the end of line 0 into line 1.
    hs_low  = 0;
    cyc     = 0;
    prev_fs = -1;
    vs_cnt  = 0;
    for (int i = 0; i < 1351; i++) begin
      drive(1'b1, 1'b0, '0);
      cyc++;
      if (cur_b.row == 12'd0 && b_hs == 1'b0) hs_low++;
      if (cur_b.row == 12'd0) begin
        case (cur_b.col)
          12'd1023: chk("von_at_1023", 32'(b_von), 32'd1);
          12'd1024: chk("von_at_1024", 32'(b_von), 32'd0);
          12'd1047: chk("hs_at_1047", 32'(b_hs), 32'd1);
          12'd1048: chk("hs_at_1048", 32'(b_hs), 32'd0);
          12'd1183: chk("hs_at_1183", 32'(b_hs), 32'd0);
          12'd1184: chk("hs_at_1184", 32'(b_hs), 32'd1);
          12'd1343: chk("col_last", 32'(b_col), 32'd1343);
          default: ;
        endcase
      end
      if (cur_b.row == 12'd1 && cur_b.col == 12'd0) begin
        chk("wrap_row", 32'(b_row), 32'd1);
        chk("wrap_col", 32'(b_col), 32'd0);
        chk("wrap_ls", 32'(b_ls), 32'd1);
        chk("wrap_fs", 32'(b_fs), 32'd0);
        chk("hs_width", 32'(hs_low), 32'd136);
      end
      if (s_vs) vs_cnt++;
      if (s_fs) begin
        if (prev_fs >= 0) begin
          chk("s_frame_period", 32'(cyc - prev_fs), 32'd150);
          chk("s_vs_cycles", 32'(vs_cnt), 32'd30);
        end
        prev_fs = cyc;
        vs_cnt  = 0;
      end
    end

    // Advance to column 500 of row 1, then reset between clock edges.
    while (!(cur_b.row == 12'd1 && cur_b.col == 12'd500)) drive(1'b1, 1'b0, '0);
    #2;
    HRESETn = 1'b0;
    #1;
    chk_reset("mid");
    model_reset();
    #2;
    HRESETn = 1'b1;
    drive(1'b1, 1'b0, '0);
    chk("post_rst_col", 32'(b_col), 32'd0);
    chk("post_rst_row", 32'(b_row), 32'd0);
    chk("post_rst_fs", 32'(b_fs), 32'd1);
    chk("post_rst_ls", 32'(b_ls), 32'd1);
    chk("post_rst_von", 32'(b_von), 32'd1);

    // Random enable pattern: outputs advance only on enabled cycles.
    for (int i = 0; i < 400; i++) drive(1'($urandom_range(0, 1)), 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Display timing generator for the 1024x768 @ 60 Hz video path. It produces the pixel_row, pixel_column and video_on scan that the world-map scaler and the colorizer consume, plus horiz_sync and vert_sync for the VGA connector.
- It advances one pixel per pix_ce tick, and presents all outputs registered and mutually aligned.

Parameters:
- H_VISIBLE, 1024, active pixels per line
- H_FPORCH, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BPORCH, 160, horizontal back porch (pixels)
- V_VISIBLE, 768, active lines per frame
- V_FPORCH, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BPORCH, 29, vertical back porch (lines)
- SYNC_POL, 0, active level of horiz_sync/vert_sync (0 = active-low)

Ports:
- HCLK  input  1  system clock; all logic rising-edge
- HRESETn  input  1  asynchronous active-low reset
- pix_ce  input  1  pixel clock enable; state advances only when 1
- pixel_column  output  12  horizontal counter value, 0..H_TOTAL-1
- pixel_row  output  12  vertical counter value, 0..V_TOTAL-1
- video_on  output  1  1 when pixel is inside the visible region
- horiz_sync  output  1  horizontal sync, polarity per SYNC_POL
- vert_sync  output  1  vertical sync, polarity per SYNC_POL
- frame_start  output  1  one-HCLK pulse marking pixel (0,0) output
- line_start  output  1  one-HCLK pulse marking column 0 output

Behaviour:
- Derived totals:
  - H_TOTAL = H_VISIBLE + H_FPORCH + H_SYNC + H_BPORCH = 1344
  - V_TOTAL = V_VISIBLE + V_FPORCH + V_SYNC + V_BPORCH = 806
- Internal counters h_cnt and v_cnt, 12 bits each.
- On pix_ce:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 when h_cnt wraps while v_cnt = V_TOTAL-1.
- pix_ce = 0: counters and all outputs hold, except the pulse outputs, which drop to 0.
- Output register stage:
  - On each pix_ce, the outputs load the decode of the current (h_cnt, v_cnt).
  - Latency: one pix_ce tick from counter to outputs. All outputs describe the same pixel in the same cycle.
- Decode:
  - video_on = (h < H_VISIBLE) && (v < V_VISIBLE)
  - horiz_sync is active for h in [H_VISIBLE+H_FPORCH, H_VISIBLE+H_FPORCH+H_SYNC), i.e. [1048, 1184)
  - vert_sync is active for v in [V_VISIBLE+V_FPORCH, V_VISIBLE+V_FPORCH+V_SYNC), i.e. [771, 777), for the whole line
  - Active level of both syncs = SYNC_POL; inactive level = ~SYNC_POL
  - pixel_column = h, pixel_row = v, unconditionally (not gated by video_on)
  - line_start = 1 for one HCLK when the loaded h = 0
  - frame_start = 1 for one HCLK when the loaded h = 0 and v = 0
- Reset, asynchronous whenever HRESETn = 0, including mid-frame:
  - h_cnt = 0, v_cnt = 0
  - pixel_column = 0, pixel_row = 0
  - video_on = 0, frame_start = 0, line_start = 0
  - horiz_sync = vert_sync = ~SYNC_POL (inactive)
- First pix_ce after reset release: outputs show (0,0) with video_on = 1 and frame_start = line_start = 1.
- pix_ce held 1 continuously is legal (generator runs at HCLK rate).
- No illegal counter states are reachable; the counters never exceed TOTAL-1.

Test Plan:
- Reset, then pix_ce = 1 for 1 cycle -> pixel_column = 0, pixel_row = 0, video_on = 1, frame_start = 1, line_start = 1, horiz_sync = 1, vert_sync = 1.
- pix_ce = 1 continuously, sample outputs at pixel_column 1023 then 1024 on row 0 -> video_on goes 1 then 0; horiz_sync goes low at 1048 and returns high at 1184 (136 ticks).
- Run to end of line 0 -> pixel_column reaches 1343, then shows 0 with pixel_row = 1; line_start pulses; frame_start stays 0.
- Run full frame -> vert_sync low exactly for rows 771..776. After pixel (1343, 805), outputs show (0,0) and frame_start pulses. Frame period = 1,083,264 ticks.
- pix_ce toggling 1-0-0-1 -> outputs advance only on pix_ce = 1 ticks; pulses last exactly one HCLK; values hold otherwise.
- Assert HRESETn = 0 at (500, 400) without an HCLK edge -> outputs go immediately to their reset values. After release, the next pix_ce yields (0,0) with frame_start = 1.
